baby_loader: RTL and testbench
==============================

// Module: baby_loader
// PURPOSE
//   Serial program loader for the Baby store. Consumes a byte stream (UART receiver output),
//   assembles 32-bit lines MSB-first and writes them into the 32-line store through its
//   write port, holding the CPU off while loading. Verifies a checksum; on success it pulses
//   start so the CPU runs the new program from line 0 without re-synthesising the memory image.
// PARAMETERS
//   WORDS    32       store lines per frame (power of two; address width = $clog2(WORDS))
//   HEADER   8'hA5    frame start byte
//   TIMEOUT  1000000  max idle clocks between bytes inside a frame before abort
// PORTS
//   clk          in   1   system clock
//   resetn       in   1   asynchronous reset, active low
//   rx_valid     in   1   one-cycle strobe: rx_data holds a new byte (may be high every cycle)
//   rx_data      in   8   received byte
//   ram_addr     out  5   store line being written
//   ram_din      out  32  line data
//   ram_we       out  1   store write enable, one cycle per line
//   cpu_hold     out  1   1 = CPU must not fetch or execute
//   start        out  1   one-cycle pulse: load good, CPU restarts at line 0
//   busy         out  1   1 while a frame is in progress
//   err_csum     out  1   last frame failed checksum
//   err_timeout  out  1   last frame aborted on timeout
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; counters, checksum and shift register 0.
//   cpu_hold=0 after reset so the built-in image runs.
//   No backpressure: every rx_valid byte is consumed in its cycle.
//   States:
//   - IDLE: rx_data==HEADER with rx_valid -> DATA; clear byte count, checksum, both
//     error flags; set busy=1, cpu_hold=1 next cycle. Other bytes ignored.
//   - DATA: each byte shifted in (word = {word[23:0],byte}); sum += byte (8-bit, wraps).
//     On 4th byte of line k accepted in cycle N: ram_we=1, ram_addr=k, ram_din=word in N+1,
//     exactly one cycle. Line WORDS-1 written -> CSUM. HEADER byte in DATA is plain data.
//   - CSUM: next byte compared with 8-bit sum of all 4*WORDS data bytes.
//     Match -> start=1 and cpu_hold=0 in the following cycle, busy=0, -> IDLE.
//     Mismatch -> err_csum=1, busy=0, cpu_hold stays 1, -> IDLE.
//   Timeout: idle counter clears on each rx_valid and counts in DATA/CSUM only.
//     Reaching TIMEOUT -> err_timeout=1, busy=0, cpu_hold stays 1, -> IDLE; store contents
//     partial.
//   cpu_hold, once set, clears only on a good frame or reset. Error flags sticky until the
//   next HEADER in IDLE or reset.
//   Final ram_we (line WORDS-1) always precedes start by >=1 cycle; CPU reads new data.
//   Reset mid-frame: immediate return to IDLE, all outputs 0; store keeps lines already
//   written.
//   Back-to-back frames: HEADER in the cycle after the checksum byte is accepted.
//   ram_addr/ram_din hold last written values while ram_we=0.
// TESTING
//   Good frame: A5, lines i=0..31 with value 32'h0000_0100*i+i, correct sum -> 32 writes
//     addr 0..31 exact data, start pulse 1 cycle, cpu_hold falls with start.
//   Bad checksum: same frame, csum+1 -> 32 writes, no start, err_csum=1, cpu_hold=1.
//     A following good frame clears err_csum and pulses start.
//   Timeout: header + 10 bytes then silence, TIMEOUT=50 -> 2 writes, err_timeout at
//     idle clock 50, busy=0, IDLE.
//   Noise in IDLE: bytes 00,FF,5A then A5 frame -> noise ignored, load succeeds.
//   Full-rate stream: rx_valid every cycle, data byte 8'hA5 inside frame -> treated as
//     data, writes one cycle after each 4th byte.
//   Reset mid-frame: resetn low after line 7 written -> outputs 0; next frame loads cleanly.

Source files
------------

// File: rtl/baby_loader.sv
// Serial program loader for the Baby store: assembles MSB-first 32-bit lines from a
// byte stream, writes them into the store, checks the frame checksum and restarts the CPU.
module baby_loader #(
    parameter int         WORDS   = 32,
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         TIMEOUT = 1000000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    output logic [$clog2(WORDS)-1:0] ram_addr,
    output logic [31:0]              ram_din,
    output logic                     ram_we,
    output logic                     cpu_hold,
    output logic                     start,
    output logic                     busy,
    output logic                     err_csum,
    output logic                     err_timeout
);

    // state  | meaning
    // S_IDLE | waiting for HEADER; CPU runs whatever the store holds unless cpu_hold is set
    // S_DATA | shifting in 4*WORDS data bytes, one store write per completed line
    // S_CSUM | next byte is compared with the running 8-bit sum of all data bytes

    localparam int            AW        = $clog2(WORDS);
    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_LINE = AW'(WORDS - 1);
    localparam logic [TW-1:0] TMR_LOAD  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CSUM = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [1:0]     byte_cnt, byte_cnt_d;
    logic [AW-1:0]  line, line_d;
    logic [7:0]     sum, sum_d;
    logic [23:0]    word, word_d;
    logic [TW-1:0]  tmr, tmr_d;
    logic [AW-1:0]  addr_d;
    logic [31:0]    din_d;
    logic           we_d, hold_d, start_d, busy_d, ecs_d, eto_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            byte_cnt    <= '0;
            line        <= '0;
            sum         <= '0;
            word        <= '0;
            tmr         <= '0;
            ram_addr    <= '0;
            ram_din     <= '0;
            ram_we      <= 1'b0;
            cpu_hold    <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            err_csum    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            byte_cnt    <= byte_cnt_d;
            line        <= line_d;
            sum         <= sum_d;
            word        <= word_d;
            tmr         <= tmr_d;
            ram_addr    <= addr_d;
            ram_din     <= din_d;
            ram_we      <= we_d;
            cpu_hold    <= hold_d;
            start       <= start_d;
            busy        <= busy_d;
            err_csum    <= ecs_d;
            err_timeout <= eto_d;
        end
    end

    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        line_d     = line;
        sum_d      = sum;
        word_d     = word;
        tmr_d      = tmr;
        addr_d     = ram_addr;
        din_d      = ram_din;
        we_d       = 1'b0;
        hold_d     = cpu_hold;
        start_d    = 1'b0;
        busy_d     = busy;
        ecs_d      = err_csum;
        eto_d      = err_timeout;

        case (state)
            S_IDLE: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_d    = S_DATA;
                    byte_cnt_d = '0;
                    line_d     = '0;
                    sum_d      = '0;
                    word_d     = '0;
                    tmr_d      = TMR_LOAD;
                    busy_d     = 1'b1;
                    hold_d     = 1'b1;
                    ecs_d      = 1'b0;
                    eto_d      = 1'b0;
                end
            end

            S_DATA: begin
                if (rx_valid) begin
                    word_d     = {word[15:0], rx_data};
                    sum_d      = sum + rx_data;
                    byte_cnt_d = byte_cnt + 2'd1;
                    tmr_d      = TMR_LOAD;
                    if (byte_cnt == 2'd3) begin
                        we_d   = 1'b1;
                        addr_d = line;
                        din_d  = {word, rx_data};
                        line_d = line + AW'(1);
                        if (line == LAST_LINE)
                            state_d = S_CSUM;
                    end
                end else if (tmr == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    eto_d   = 1'b1;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end

            S_CSUM: begin
                if (rx_valid) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    // cpu_hold drops together with start so the CPU restarts on fresh lines
                    if (rx_data == sum) begin
                        start_d = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        ecs_d = 1'b1;
                    end
                end else if (tmr == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    eto_d   = 1'b1;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_baby_loader.sv
// Self-checking bench for baby_loader: random and directed frames against a byte-level model.
module tb_baby_loader;

    localparam int         WORDS = 32;
    localparam logic [7:0] HDR   = 8'hA5;
    localparam int         TOUT  = 50;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [4:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic        cpu_hold;
    logic        start;
    logic        busy;
    logic        err_csum;
    logic        err_timeout;

    baby_loader #(.WORDS(WORDS), .HEADER(HDR), .TIMEOUT(TOUT)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .cpu_hold    (cpu_hold),
        .start       (start),
        .busy        (busy),
        .err_csum    (err_csum),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int         cyc = 0;
    int         start_cnt = 0;
    int         checks = 0;
    int         failures = 0;
    wr_t        obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] fb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we === 1'b1) obs_q.push_back('{int'(ram_addr), ram_din, cyc});
        if (start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic gap(input int gap_max);
        int g;
        g = (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
        repeat (g) tick();
    endtask

    task automatic build_frame(input bit counting);
        fb.delete();
        for (int i = 0; i < WORDS; i++) begin
            logic [31:0] v;
            if (counting) v = 32'h100 * i + i;
            else          v = $urandom;
            for (int k = 3; k >= 0; k--) begin
                if (!counting && $urandom_range(0, 7) == 0) fb.push_back(HDR);
                else                                        fb.push_back(v[8*k +: 8]);
            end
        end
        if (!counting) fb[5] = HDR;
    endtask

    function automatic logic [7:0] ref_sum();
        logic [7:0] s = 8'h00;
        foreach (fb[k]) s = s + fb[k];
        return s;
    endfunction

    // Send fb[idx] and, if it completes a line, record the write the store must see.
    task automatic send_data(input int idx);
        send(fb[idx]);
        if (idx % 4 == 3)
            exp_q.push_back('{idx / 4, {fb[idx-3], fb[idx-2], fb[idx-1], fb[idx]}, cyc});
    endtask

    task automatic check_writes(input string tag);
        int n;
        chkw({tag, "_wr_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chkw($sformatf("%s_wr%0d_addr", tag, i), obs_q[i].addr, exp_q[i].addr);
            chkw($sformatf("%s_wr%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
            chkw($sformatf("%s_wr%0d_cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chkw({tag, "_addr"}, 32'(ram_addr), 0);
        chkw({tag, "_din"}, ram_din, 0);
        chkb({tag, "_we"}, ram_we, 1'b0);
        chkb({tag, "_hold"}, cpu_hold, 1'b0);
        chkb({tag, "_start"}, start, 1'b0);
        chkb({tag, "_busy"}, busy, 1'b0);
        chkb({tag, "_ecs"}, err_csum, 1'b0);
        chkb({tag, "_eto"}, err_timeout, 1'b0);
    endtask

    task automatic run_frame(input string tag, input int gap_max, input logic [7:0] delta,
                             input bit b2b);
        int         s0;
        bit         good;
        logic [7:0] cs;
        obs_q.delete();
        exp_q.delete();
        good = (delta == 8'h00);
        send(HDR);
        chkb({tag, "_hdr_busy"}, busy, 1'b1);
        chkb({tag, "_hdr_hold"}, cpu_hold, 1'b1);
        chkb({tag, "_hdr_ecs"}, err_csum, 1'b0);
        chkb({tag, "_hdr_eto"}, err_timeout, 1'b0);
        for (int i = 0; i < 4 * WORDS; i++) begin
            gap(gap_max);
            send_data(i);
        end
        gap(gap_max);
        chkb({tag, "_pre_csum_busy"}, busy, 1'b1);
        s0 = start_cnt;
        cs = ref_sum() + delta;
        send(cs);
        chkb({tag, "_start"}, start, good);
        chkb({tag, "_hold"}, cpu_hold, !good);
        chkb({tag, "_busy"}, busy, 1'b0);
        chkb({tag, "_ecs"}, err_csum, !good);
        check_writes(tag);
        chkw({tag, "_addr_hold"}, 32'(ram_addr), WORDS - 1);
        chkw({tag, "_din_hold"}, ram_din, {fb[4*WORDS-4], fb[4*WORDS-3], fb[4*WORDS-2], fb[4*WORDS-1]});
        if (!b2b) begin
            tick();
            chkw({tag, "_start_pulses"}, start_cnt - s0, good ? 1 : 0);
            chkb({tag, "_start_low"}, start, 1'b0);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        resetn = 1'b1;
        tick();

        build_frame(1'b1);
        run_frame("good_cnt", 3, 8'h00, 1'b0);

        run_frame("bad_csum", 2, 8'h01, 1'b0);
        chkb("bad_csum_ecs_sticky", err_csum, 1'b1);
        chkb("bad_csum_hold_sticky", cpu_hold, 1'b1);

        build_frame(1'b0);
        run_frame("good_rand", 3, 8'h00, 1'b0);

        // timeout: header + 10 bytes then silence
        build_frame(1'b0);
        obs_q.delete();
        exp_q.delete();
        send(HDR);
        for (int i = 0; i < 10; i++) send_data(i);
        repeat (TOUT - 1) tick();
        chkb("tout_not_yet", err_timeout, 1'b0);
        chkb("tout_busy_before", busy, 1'b1);
        tick();
        chkb("tout_flag", err_timeout, 1'b1);
        chkb("tout_busy", busy, 1'b0);
        chkb("tout_hold", cpu_hold, 1'b1);
        repeat (5) tick();
        check_writes("tout");

        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        chkb("noise_busy", busy, 1'b0);
        chkb("noise_eto_kept", err_timeout, 1'b1);
        build_frame(1'b1);
        run_frame("after_noise", 1, 8'h00, 1'b0);

        build_frame(1'b0);
        run_frame("fullrate_a", 0, 8'h00, 1'b1);
        build_frame(1'b0);
        run_frame("fullrate_b", 0, 8'h00, 1'b0);

        // reset after line 7 has been written
        build_frame(1'b1);
        obs_q.delete();
        exp_q.delete();
        send(HDR);
        for (int i = 0; i < 32; i++) send_data(i);
        tick();
        check_writes("pre_reset");
        #2 resetn = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        tick();
        resetn = 1'b1;
        tick();
        check_idle_outputs("post_reset");
        build_frame(1'b0);
        run_frame("after_reset", 2, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
